// File: rtl/risc_controller_pkg.sv
// Shared definitions for the accumulator-CPU controller: opcode encodings, phase
// encodings, the strobe bundle and the phase-advance helper.
package risc_controller_pkg;

   localparam int OPCODE_WIDTH_DEF = 3;
   localparam int ICNT_WIDTH_DEF   = 16;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic ld_ac;
      logic wr;
      logic data_e;
      logic halt;
   } strobes_t;

   function automatic phase_e next_phase(input phase_e p);
      phase_e n;
      case (p)
         INST_ADDR:  n = INST_FETCH;
         INST_FETCH: n = INST_LOAD;
         INST_LOAD:  n = IDLE;
         IDLE:       n = OP_ADDR;
         OP_ADDR:    n = OP_FETCH;
         OP_FETCH:   n = ALU_OP;
         ALU_OP:     n = STORE;
         STORE:      n = INST_ADDR;
         default:    n = INST_ADDR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath bundle: IR opcode and ALU zero flag in, strobes and
// debug state out.
interface risc_controller_if #(
   parameter int OPCODE_WIDTH = 3,
   parameter int ICNT_WIDTH   = 16
);
   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    a_is_zero;
   logic                    sel;
   logic                    rd;
   logic                    ld_ir;
   logic                    inc_pc;
   logic                    ld_pc;
   logic                    ld_ac;
   logic                    wr;
   logic                    data_e;
   logic                    halt;
   logic [2:0]              phase;
   logic [ICNT_WIDTH-1:0]   icnt;

   modport master (
      input  opcode, a_is_zero,
      output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, icnt
   );

   modport slave (
      output opcode, a_is_zero,
      input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, icnt
   );
endinterface

// File: rtl/risc_ctrl_decode.sv
// Pure combinational strobe table: (phase, opcode, a_is_zero, halted) -> strobes.
// Opcodes outside the known set decode as a NOP (no bus or register activity).
module risc_ctrl_decode
   import risc_controller_pkg::*;
#(
   parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
   input  phase_e                  phase,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    a_is_zero,
   input  logic                    halted,
   output strobes_t                strobes
);

   logic is_hlt;
   logic is_skz;
   logic is_sto;
   logic is_jmp;
   logic is_aluop;

   assign is_hlt   = (opcode == OPCODE_WIDTH'(OP_HLT));
   assign is_skz   = (opcode == OPCODE_WIDTH'(OP_SKZ));
   assign is_sto   = (opcode == OPCODE_WIDTH'(OP_STO));
   assign is_jmp   = (opcode == OPCODE_WIDTH'(OP_JMP));
   assign is_aluop = (opcode == OPCODE_WIDTH'(OP_ADD)) | (opcode == OPCODE_WIDTH'(OP_AND)) |
                     (opcode == OPCODE_WIDTH'(OP_XOR)) | (opcode == OPCODE_WIDTH'(OP_LDA));

   // Once halted only the halt flag survives, so the HLT inc_pc pulse is never repeated.
   always_comb begin
      strobes = '0;
      if (halted) begin
         strobes.halt = 1'b1;
      end else begin
         case (phase)
            INST_ADDR: begin
               strobes.sel = 1'b1;
            end
            INST_FETCH: begin
               strobes.sel = 1'b1;
               strobes.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               strobes.sel   = 1'b1;
               strobes.rd    = 1'b1;
               strobes.ld_ir = 1'b1;
            end
            OP_ADDR: begin
               strobes.inc_pc = 1'b1;
               strobes.halt   = is_hlt;
            end
            OP_FETCH: begin
               strobes.rd = is_aluop;
            end
            ALU_OP: begin
               strobes.rd     = is_aluop;
               strobes.inc_pc = is_skz & a_is_zero;
               strobes.ld_pc  = is_jmp;
               strobes.data_e = is_sto;
            end
            STORE: begin
               strobes.rd     = is_aluop;
               strobes.ld_ac  = is_aluop;
               strobes.ld_pc  = is_jmp;
               strobes.wr     = is_sto;
               strobes.data_e = is_sto;
            end
            default: begin
               strobes = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/risc_controller.sv
// 8-phase instruction sequencer for the accumulator CPU: phase register, sticky
// halt, retired-instruction counter. Optional single-step gate under CTRL_STEP_EN.
module risc_controller
   import risc_controller_pkg::*;
#(
   parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
   parameter int ICNT_WIDTH   = ICNT_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
`ifdef CTRL_STEP_EN
   input  logic step,
`endif
   risc_controller_if.master bus
);

   phase_e                phase_q, phase_d;
   logic                  halt_q, halt_d;
   logic [ICNT_WIDTH-1:0] icnt_q, icnt_d;
   logic                  step_go;
   logic                  is_hlt;
   strobes_t              strobes;

`ifdef CTRL_STEP_EN
   assign step_go = step;
`else
   assign step_go = 1'b1;
`endif

   assign is_hlt = (bus.opcode == OPCODE_WIDTH'(OP_HLT));

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q <= INST_ADDR;
         halt_q  <= 1'b0;
         icnt_q  <= '0;
      end else begin
         phase_q <= phase_d;
         halt_q  <= halt_d;
         icnt_q  <= icnt_d;
      end
   end

   // Next state: HLT freezes the phase at OP_ADDR; only a completed STORE retires.
   always_comb begin
      phase_d = phase_q;
      halt_d  = halt_q;
      icnt_d  = icnt_q;
      if (halt_q) begin
         phase_d = phase_q;
      end else if ((phase_q == OP_ADDR) && is_hlt) begin
         halt_d = 1'b1;
      end else if ((phase_q == INST_ADDR) && !step_go) begin
         phase_d = phase_q;
      end else begin
         phase_d = next_phase(phase_q);
         if (phase_q == STORE) begin
            icnt_d = icnt_q + ICNT_WIDTH'(1);
         end else begin
            icnt_d = icnt_q;
         end
      end
   end

   risc_ctrl_decode #(
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_decode (
      .phase     (phase_q),
      .opcode    (bus.opcode),
      .a_is_zero (bus.a_is_zero),
      .halted    (halt_q),
      .strobes   (strobes)
   );

   // Output drive onto the bundle.
   always_comb begin
      bus.sel    = strobes.sel;
      bus.rd     = strobes.rd;
      bus.ld_ir  = strobes.ld_ir;
      bus.inc_pc = strobes.inc_pc;
      bus.ld_pc  = strobes.ld_pc;
      bus.ld_ac  = strobes.ld_ac;
      bus.wr     = strobes.wr;
      bus.data_e = strobes.data_e;
      bus.halt   = strobes.halt;
      bus.phase  = phase_q;
      bus.icnt   = icnt_q;
   end

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller: directed instruction walks with literal
// expectations, then randomized opcodes/resets against a phase-count model.
module tb_risc_controller;
   import risc_controller_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
`ifdef CTRL_STEP_EN
   logic step;
`endif
   int   checks   = 0;
   int   failures = 0;
   bit   cmp_en   = 1'b0;

   logic [2:0]  m_phase;
   logic        m_halt;
   logic [15:0] m_icnt;

   always #5 clk = ~clk;

   risc_controller_if #(.OPCODE_WIDTH(3), .ICNT_WIDTH(16)) bus();

   risc_controller #(.OPCODE_WIDTH(3), .ICNT_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef CTRL_STEP_EN
      .step  (step),
`endif
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: phase is a count mod 8, an instruction retires each time the count wraps.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase <= 3'd0;
         m_halt  <= 1'b0;
         m_icnt  <= 16'd0;
      end else if (!m_halt) begin
         if (m_phase == 3'd4 && bus.opcode == OP_HLT) m_halt <= 1'b1;
`ifdef CTRL_STEP_EN
         else if (m_phase == 3'd0 && !step) m_phase <= m_phase;
`endif
         else begin
            m_phase <= m_phase + 3'd1;
            if (m_phase == 3'd7) m_icnt <= m_icnt + 16'd1;
         end
      end
   end

   // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt} from the strobe rules.
   function automatic logic [8:0] expect_out(input int ph, input bit hlt, input int op, input bit z);
      logic aluop;
      aluop = (op >= 2 && op <= 5);
      if (hlt) return 9'b0_0000_0001;
      return {ph <= 3,
              (ph >= 1 && ph <= 3) || (ph >= 5 && aluop),
              ph == 2 || ph == 3,
              ph == 4 || (ph == 6 && op == 1 && z),
              op == 7 && ph >= 6,
              aluop && ph == 7,
              op == 6 && ph == 7,
              op == 6 && ph >= 6,
              ph == 4 && op == 0};
   endfunction

   // Single compare point, mid-cycle, every cycle after the first reset edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("strobes",
               32'({bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac, bus.wr, bus.data_e, bus.halt}),
               32'(expect_out(int'(m_phase), m_halt, int'(bus.opcode), bus.a_is_zero)));
         check("phase", 32'(bus.phase), 32'(m_phase));
         check("icnt", 32'(bus.icnt), 32'(m_icnt));
      end
   end

   task automatic do_instr(input logic [2:0] op, input logic z,
                           output logic [7:0] rd_v, output logic [7:0] inc_v, output logic [7:0] ldpc_v,
                           output logic [7:0] ldac_v, output logic [7:0] wr_v, output logic [7:0] de_v,
                           output logic [7:0] ldir_v);
      bus.opcode    = op;
      bus.a_is_zero = z;
      for (int p = 0; p < 8; p++) begin
         @(negedge clk);
         check("seq_phase", 32'(bus.phase), 32'(p));
         rd_v[p]   = bus.rd;
         inc_v[p]  = bus.inc_pc;
         ldpc_v[p] = bus.ld_pc;
         ldac_v[p] = bus.ld_ac;
         wr_v[p]   = bus.wr;
         de_v[p]   = bus.data_e;
         ldir_v[p] = bus.ld_ir;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd_v, inc_v, ldpc_v, ldac_v, wr_v, de_v, ldir_v;
      logic       seen;
      rst_n         = 1'b0;
      bus.opcode    = OP_ADD;
      bus.a_is_zero = 1'b0;
`ifdef CTRL_STEP_EN
      step          = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      #1;
      check("rst_phase", 32'(bus.phase), 32'd0);
      check("rst_strobes",
            32'({bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac, bus.wr, bus.data_e, bus.halt}),
            32'h100);
      check("rst_icnt", 32'(bus.icnt), 32'd0);

      do_instr(OP_ADD, 1'b0, rd_v, inc_v, ldpc_v, ldac_v, wr_v, de_v, ldir_v);
      check("add_rd", 32'(rd_v), 32'hEE);
      check("add_ld_ir", 32'(ldir_v), 32'h0C);
      check("add_inc_pc", 32'(inc_v), 32'h10);
      check("add_ld_ac", 32'(ldac_v), 32'h80);
      check("add_icnt", 32'(bus.icnt), 32'd1);
      check("model_icnt_add", 32'(m_icnt), 32'd1);

      do_instr(OP_SKZ, 1'b1, rd_v, inc_v, ldpc_v, ldac_v, wr_v, de_v, ldir_v);
      check("skz_z1_inc_pc", 32'(inc_v), 32'h50);
      do_instr(OP_SKZ, 1'b0, rd_v, inc_v, ldpc_v, ldac_v, wr_v, de_v, ldir_v);
      check("skz_z0_inc_pc", 32'(inc_v), 32'h10);

      do_instr(OP_STO, 1'b0, rd_v, inc_v, ldpc_v, ldac_v, wr_v, de_v, ldir_v);
      check("sto_data_e", 32'(de_v), 32'hC0);
      check("sto_wr", 32'(wr_v), 32'h80);
      check("sto_rd", 32'(rd_v), 32'h0E);
      do_instr(OP_JMP, 1'b0, rd_v, inc_v, ldpc_v, ldac_v, wr_v, de_v, ldir_v);
      check("jmp_ld_pc", 32'(ldpc_v), 32'hC0);
      check("jmp_wr", 32'(wr_v), 32'h00);
      check("model_icnt_5", 32'(m_icnt), 32'd5);

      // HLT: halt appears in phase 4 and the sequencer freezes there.
      bus.opcode = OP_HLT;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("hlt_phase", 32'(bus.phase), 32'd4);
      check("hlt_halt", 32'(bus.halt), 32'd1);
      check("hlt_inc_pc", 32'(bus.inc_pc), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("halted_phase", 32'(bus.phase), 32'd4);
         check("halted_halt", 32'(bus.halt), 32'd1);
         check("halted_inc_pc", 32'(bus.inc_pc), 32'd0);
         check("halted_icnt", 32'(bus.icnt), 32'd5);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("unhalt_phase", 32'(bus.phase), 32'd0);
      check("unhalt_halt", 32'(bus.halt), 32'd0);
      check("unhalt_icnt", 32'(bus.icnt), 32'd0);

      // Reset in the middle of LDA: ld_ac must never fire.
      bus.opcode = OP_LDA;
      seen       = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | bus.ld_ac;
         @(posedge clk);
         #1;
      end
      check("lda_mid_phase", 32'(bus.phase), 32'd5);
      rst_n = 1'b0;
      @(negedge clk);
      seen = seen | bus.ld_ac;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("lda_rst_phase", 32'(bus.phase), 32'd0);
      check("lda_rst_icnt", 32'(bus.icnt), 32'd0);
      check("lda_no_ld_ac", 32'(seen), 32'd0);

      // Randomized run: opcode changes only at INST_ADDR, occasional resets.
      for (int i = 0; i < 4000; i++) begin
         int r;
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         if (m_halt && $urandom_range(0, 7) == 0) rst_n = 1'b0;
         else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         if (m_phase == 3'd0) begin
            r = $urandom_range(0, 15);
            bus.opcode = (r == 0) ? OP_HLT : 3'(1 + (r % 7));
         end
         bus.a_is_zero = 1'($urandom_range(0, 1));
`ifdef CTRL_STEP_EN
         step = ($urandom_range(0, 3) != 0);
`endif
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

`ifdef CTRL_STEP_EN
      // Step gate: drop step before the wrap; phase must park at INST_ADDR.
      step       = 1'b1;
      bus.opcode = OP_ADD;
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      step = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("step_hold_phase", 32'(bus.phase), 32'd0);
         check("step_hold_sel", 32'(bus.sel), 32'd1);
         @(posedge clk);
         #1;
      end
      check("step_icnt", 32'(bus.icnt), 32'd1);
      step = 1'b1;
      @(posedge clk);
      #1;
      check("step_go_phase", 32'(bus.phase), 32'd1);
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
